// File: rtl/img_crop_pkg.sv
// Shared types and defaults for the img_crop region-of-interest crop stage.
package img_crop_pkg;

    localparam int unsigned COORD_WIDTH_DEF = 13;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } crop_state_t;

    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] x0;
        logic [COORD_WIDTH_DEF-1:0] y0;
        logic [COORD_WIDTH_DEF-1:0] w;
        logic [COORD_WIDTH_DEF-1:0] h;
    } crop_win_t;

endpackage

// File: rtl/img_crop_out_reg.sv
// One-entry AXI4-Stream output register; accepts a new beat whenever it is
// empty or being drained this cycle, and never while reset is asserted.
module img_crop_out_reg #(
    parameter int unsigned TDATA_WIDTH   = 16,
    parameter int unsigned TDATA_WIDTH_B = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [TDATA_WIDTH-1:0]   tdata_i,
    input  logic [TDATA_WIDTH_B-1:0] tstrb_i,
    input  logic [TDATA_WIDTH_B-1:0] tkeep_i,
    input  logic                     tlast_i,
    input  logic                     tuser_i,
    input  logic                     tid_i,
    input  logic                     tdest_i,
    output logic                     in_ready_c_o,
    output logic [TDATA_WIDTH-1:0]   tdata_o,
    output logic [TDATA_WIDTH_B-1:0] tstrb_o,
    output logic [TDATA_WIDTH_B-1:0] tkeep_o,
    output logic                     tvalid_o,
    output logic                     tlast_o,
    output logic                     tuser_o,
    output logic                     tid_o,
    output logic                     tdest_o,
    input  logic                     tready_i
);

    localparam int unsigned PW = TDATA_WIDTH + 2 * TDATA_WIDTH_B + 4;

    logic          valid_q, valid_d;
    logic [PW-1:0] pay_q, pay_d;
    logic          ready_c;

    assign ready_c      = rst_i && (!valid_q || tready_i);
    assign in_ready_c_o = ready_c;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (ready_c) begin
            valid_d = load_i;
            if (load_i) begin
                pay_d = {tdata_i, tstrb_i, tkeep_i, tlast_i, tuser_i, tid_i, tdest_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign tvalid_o = valid_q;
    assign {tdata_o, tstrb_o, tkeep_o, tlast_o, tuser_o, tid_o, tdest_o} = pay_q;

endmodule

// File: rtl/img_crop.sv
// Region-of-interest crop: tracks (x,y) from tuser/tlast, keeps beats inside a
// per-frame shadow window and regenerates tuser/tlast for the cropped frame.
module img_crop
    import img_crop_pkg::*;
#(
    parameter int unsigned PX_WIDTH      = 10,
    parameter int unsigned TDATA_WIDTH   = 16,
    parameter int unsigned TDATA_WIDTH_B = 2,
    parameter int unsigned COORD_WIDTH   = COORD_WIDTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [COORD_WIDTH-1:0]   crop_x0_i,
    input  logic [COORD_WIDTH-1:0]   crop_y0_i,
    input  logic [COORD_WIDTH-1:0]   crop_w_i,
    input  logic [COORD_WIDTH-1:0]   crop_h_i,
    input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
    input  logic [TDATA_WIDTH_B-1:0] video_i_tstrb,
    input  logic [TDATA_WIDTH_B-1:0] video_i_tkeep,
    input  logic                     video_i_tvalid,
    input  logic                     video_i_tlast,
    input  logic                     video_i_tuser,
    input  logic                     video_i_tid,
    input  logic                     video_i_tdest,
    output logic                     video_i_tready,
    output logic [TDATA_WIDTH-1:0]   video_o_tdata,
    output logic [TDATA_WIDTH_B-1:0] video_o_tstrb,
    output logic [TDATA_WIDTH_B-1:0] video_o_tkeep,
    output logic                     video_o_tvalid,
    output logic                     video_o_tlast,
    output logic                     video_o_tuser,
    output logic                     video_o_tid,
    output logic                     video_o_tdest,
    input  logic                     video_o_tready
);

    localparam int unsigned CW = COORD_WIDTH;
    localparam logic [CW-1:0] COORD_MAX = '1;

    // The window struct is fixed at the package coordinate width.
    if ((PX_WIDTH > TDATA_WIDTH) || (COORD_WIDTH != COORD_WIDTH_DEF)) begin : g_param_check
        $error("img_crop: unsupported PX_WIDTH or COORD_WIDTH");
    end

    crop_state_t   state_q, state_d;
    crop_win_t     win_q, win_d, win_c;
    logic [CW-1:0] x_q, x_d, y_q, y_d, x_c, y_c;
    logic [CW:0]   x_end_c, y_end_c;
    logic          in_ready_c, accept_c, sof_c;
    logic          keep_c, out_user_c, out_last_c;

    assign accept_c = video_i_tvalid && in_ready_c;
    assign sof_c    = accept_c && video_i_tuser;

    // Next state, counters, shadow window and keep decision for the current beat.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        x_d        = x_q;
        y_d        = y_q;
        win_c      = win_q;
        x_c        = x_q;
        y_c        = y_q;
        x_end_c    = '0;
        y_end_c    = '0;
        keep_c     = 1'b0;
        out_user_c = 1'b0;
        out_last_c = 1'b0;

        // A tuser beat is (0,0) and is judged against the freshly sampled window.
        if (sof_c) begin
            win_c = '{x0: crop_x0_i, y0: crop_y0_i, w: crop_w_i, h: crop_h_i};
            x_c   = '0;
            y_c   = '0;
        end
        x_end_c = (CW+1)'(win_c.x0) + (CW+1)'(win_c.w);
        y_end_c = (CW+1)'(win_c.y0) + (CW+1)'(win_c.h);

        case (state_q)
            WAIT_SOF: if (sof_c) state_d = ACTIVE;
            ACTIVE:   state_d = ACTIVE;
            default:  state_d = WAIT_SOF;
        endcase

        if (accept_c && ((state_q == ACTIVE) || video_i_tuser)) begin
            win_d      = win_c;
            keep_c     = (x_c >= win_c.x0) && ((CW+1)'(x_c) < x_end_c) &&
                         (y_c >= win_c.y0) && ((CW+1)'(y_c) < y_end_c);
            out_user_c = (x_c == win_c.x0) && (y_c == win_c.y0);
            out_last_c = ((CW+1)'(x_c) == (x_end_c - (CW+1)'(1))) || video_i_tlast;
            if (video_i_tlast) begin
                x_d = '0;
                y_d = (y_c == COORD_MAX) ? y_c : y_c + CW'(1);
            end else begin
                x_d = (x_c == COORD_MAX) ? x_c : x_c + CW'(1);
                y_d = y_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= WAIT_SOF;
            win_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    img_crop_out_reg #(
        .TDATA_WIDTH   (TDATA_WIDTH),
        .TDATA_WIDTH_B (TDATA_WIDTH_B)
    ) u_out_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (keep_c),
        .tdata_i      (video_i_tdata),
        .tstrb_i      (video_i_tstrb),
        .tkeep_i      (video_i_tkeep),
        .tlast_i      (out_last_c),
        .tuser_i      (out_user_c),
        .tid_i        (video_i_tid),
        .tdest_i      (video_i_tdest),
        .in_ready_c_o (in_ready_c),
        .tdata_o      (video_o_tdata),
        .tstrb_o      (video_o_tstrb),
        .tkeep_o      (video_o_tkeep),
        .tvalid_o     (video_o_tvalid),
        .tlast_o      (video_o_tlast),
        .tuser_o      (video_o_tuser),
        .tid_o        (video_o_tid),
        .tdest_o      (video_o_tdest),
        .tready_i     (video_o_tready)
    );

    assign video_i_tready = in_ready_c;

endmodule
